// File: rtl/ps2_host_tx_pkg.sv
// rtl/ps2_host_tx_pkg.sv - shared PS/2 command bytes, frame constants and helpers
package ps2_host_tx_pkg;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam int FILTER_LEN = 8;
    localparam int REQ_CYCLES = 28;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer, 8-sample stability filter and fall strobe
module ps2_line_filter
    import ps2_host_tx_pkg::*;
(
    input  logic clk28,
    input  logic rst_n,
    input  logic pin_in,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q, filt_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter tracks consecutive samples that disagree with the filtered level.
    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = filt_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with ACK check and timeout
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 28_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit
);

    localparam int N_INH       = CLK_FREQ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = TIMEOUT_MS * CLK_FREQ / 1000;
    localparam int TMR_W       = $clog2(max_int(N_INH, TIMEOUT_CYC) + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    logic clk_level, clk_fall, dat_level;

    ps2_line_filter u_clk_filter (
        .clk28  (clk28),
        .rst_n  (rst_n),
        .pin_in (ps2_clk_in),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_line_filter u_dat_filter (
        .clk28  (clk28),
        .rst_n  (rst_n),
        .pin_in (ps2_dat_in),
        .level  (dat_level),
        .fall   ()
    );

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             ack_ok_q, ack_ok_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             inhibit_q, inhibit_d;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        parity_d  = parity_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && ready_q) begin
                    data_d    = tx_data;
                    parity_d  = odd_parity(tx_data);
                    bit_cnt_d = '0;
                    tmr_d     = '0;
                    clk_oe_d  = 1'b1;
                    dat_oe_d  = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (tmr_q == TMR_W'(N_INH - 1)) begin
                    tmr_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_REQ: begin
                if (tmr_q == TMR_W'(REQ_CYCLES - 1)) begin
                    tmr_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = ST_DATA;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_DATA, ST_ACK, ST_WAIT_IDLE: begin
                tmr_d = tmr_q + 1'b1;
                // A dead device must never leave the bus held; timeout beats any edge.
                if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (state_q == ST_DATA) begin
                    if (clk_fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            dat_oe_d = ~parity_q;
                        end else if (bit_cnt_q == 4'd9) begin
                            dat_oe_d = 1'b0;
                        end else begin
                            ack_ok_d = ~dat_level;
                            state_d  = ST_ACK;
                        end
                    end
                end else if (state_q == ST_ACK) begin
                    state_d = ST_WAIT_IDLE;
                end else if (clk_level && dat_level) begin
                    done_d  = ack_ok_q;
                    error_d = ~ack_ok_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Ready lags the return to idle by a cycle so it rises after the result pulse.
        ready_d   = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        inhibit_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            ack_ok_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            inhibit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            ack_ok_q  <= ack_ok_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            inhibit_q <= inhibit_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_ready   = ready_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign rx_inhibit = inhibit_q;

endmodule
